// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR/trap sequencer: runs Zicsr read-modify-write ops and serialises
// ECALL entry / MRET return into one CSR write per cycle, with the fetch redirect.
module csr_trap_ctrl #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] ECALL_CAUSE = 32'd11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_pc,
    input  logic [11:0]     in_csr_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic            in_rs1_zero,
    output logic            csr_we,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic [XLEN-1:0] mstatus_in,
    input  logic [XLEN-1:0] mepc_in,
    input  logic [XLEN-1:0] mtvec_in,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

    typedef enum logic [2:0] {
        IDLE,
        CSR_EXEC,
        TRAP_EPC,
        TRAP_CAUSE,
        TRAP_ST,
        MRET_ST
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q;
    logic [XLEN-1:0] pc_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] rs1_q;
    logic            rs1z_q;
    logic            accept;

    // Trap entry: stash MIE into MPIE, disable interrupts, previous privilege = M.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        r        = m;
        r[7]     = m[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE, set MPIE, MPP stays M (M-only hart).
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        r        = m;
        r[3]     = m[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            pc_q   <= '0;
            addr_q <= '0;
            rs1_q  <= '0;
            rs1z_q <= 1'b0;
        end else if (accept) begin
            op_q   <= in_op;
            pc_q   <= in_pc;
            addr_q <= in_csr_addr;
            rs1_q  <= in_rs1_data;
            rs1z_q <= in_rs1_zero;
        end
    end

    always_comb begin
        state_d        = state_q;
        in_ready       = 1'b0;
        busy           = 1'b1;
        csr_we         = 1'b0;
        csr_addr       = '0;
        csr_wdata      = '0;
        wb_valid       = 1'b0;
        wb_data        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    case (in_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = CSR_EXEC;
                        OP_ECALL:                     state_d = TRAP_EPC;
                        OP_MRET:                      state_d = MRET_ST;
                        default:                      state_d = IDLE;
                    endcase
                end
            end
            CSR_EXEC: begin
                csr_addr = addr_q;
                wb_valid = 1'b1;
                wb_data  = csr_rdata;
                case (op_q)
                    OP_CSRRS: begin
                        csr_we    = !rs1z_q;
                        csr_wdata = csr_rdata | rs1_q;
                    end
                    OP_CSRRC: begin
                        csr_we    = !rs1z_q;
                        csr_wdata = csr_rdata & ~rs1_q;
                    end
                    default: begin
                        csr_we    = 1'b1;
                        csr_wdata = rs1_q;
                    end
                endcase
                state_d = IDLE;
            end
            TRAP_EPC: begin
                csr_we    = 1'b1;
                csr_addr  = ADDR_MEPC;
                csr_wdata = pc_q & ALIGN_MASK;
                state_d   = TRAP_CAUSE;
            end
            TRAP_CAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = ADDR_MCAUSE;
                csr_wdata = ECALL_CAUSE;
                state_d   = TRAP_ST;
            end
            TRAP_ST: begin
                csr_we         = 1'b1;
                csr_addr       = ADDR_MSTATUS;
                csr_wdata      = trap_mstatus(mstatus_in);
                redirect_valid = 1'b1;
                redirect_pc    = mtvec_in & ALIGN_MASK;
                state_d        = IDLE;
            end
            MRET_ST: begin
                csr_we         = 1'b1;
                csr_addr       = ADDR_MSTATUS;
                csr_wdata      = mret_mstatus(mstatus_in);
                redirect_valid = 1'b1;
                redirect_pc    = mepc_in;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed cases plus randomized ops against
// a per-instruction model that lists the expected CSR-port activity cycle by cycle.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_pc;
    logic [11:0] in_csr_addr;
    logic [31:0] in_rs1_data;
    logic        in_rs1_zero;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] mstatus_in;
    logic [31:0] mepc_in;
    logic [31:0] mtvec_in;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    csr_trap_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
        .in_csr_addr(in_csr_addr), .in_rs1_data(in_rs1_data), .in_rs1_zero(in_rs1_zero),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .mstatus_in(mstatus_in), .mepc_in(mepc_in), .mtvec_in(mtvec_in),
        .wb_valid(wb_valid), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] a;
        logic [31:0] wd;
        logic        wb;
        logic [31:0] wbd;
        logic        rv;
        logic [31:0] rpc;
    } cyc_t;

    cyc_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".ctl"}, {28'd0, busy, csr_we, wb_valid, redirect_valid}, 32'd0);
        chk({tag, ".csr_addr"}, {20'd0, csr_addr}, 32'd0);
        chk({tag, ".csr_wdata"}, csr_wdata, 32'd0);
        chk({tag, ".wb_data"}, wb_data, 32'd0);
        chk({tag, ".redirect_pc"}, redirect_pc, 32'd0);
    endtask

    function automatic cyc_t mk(input logic we, input logic [11:0] a, input logic [31:0] wd,
                                input logic wb, input logic [31:0] wbd,
                                input logic rv, input logic [31:0] rpc);
        cyc_t c;
        c.we = we; c.a = a; c.wd = wd; c.wb = wb; c.wbd = wbd; c.rv = rv; c.rpc = rpc;
        return c;
    endfunction

    // Expected per-cycle CSR port activity for one instruction, from the ISA rules.
    task automatic build_model(input logic [2:0] op, input logic [31:0] pc, input logic [11:0] a,
                               input logic [31:0] rs1, input logic rs1z, input logic [31:0] old,
                               input logic [31:0] ms, input logic [31:0] epc, input logic [31:0] tvec);
        logic [31:0] n;
        exp_q.delete();
        case (op)
            3'd0: exp_q.push_back(mk(1'b1, a, rs1, 1'b1, old, 1'b0, 32'd0));
            3'd1: exp_q.push_back(mk(!rs1z, a, old | rs1, 1'b1, old, 1'b0, 32'd0));
            3'd2: exp_q.push_back(mk(!rs1z, a, old & ~rs1, 1'b1, old, 1'b0, 32'd0));
            3'd3: begin
                n = (ms & ~32'h0000_1888) | (((ms >> 3) & 32'd1) << 7) | 32'h0000_1800;
                exp_q.push_back(mk(1'b1, 12'h341, pc - (pc % 4), 1'b0, 32'd0, 1'b0, 32'd0));
                exp_q.push_back(mk(1'b1, 12'h342, 32'd11, 1'b0, 32'd0, 1'b0, 32'd0));
                exp_q.push_back(mk(1'b1, 12'h300, n, 1'b0, 32'd0, 1'b1, tvec - (tvec % 4)));
            end
            3'd4: begin
                n = (ms & ~32'h0000_1888) | (((ms >> 7) & 32'd1) << 3) | 32'h0000_1880;
                exp_q.push_back(mk(1'b1, 12'h300, n, 1'b0, 32'd0, 1'b1, epc));
            end
            default: ;
        endcase
    endtask

    // Drive one instruction from IDLE (called on a negedge) and check every cycle until IDLE again.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] pc,
                          input logic [11:0] a, input logic [31:0] rs1, input logic rs1z,
                          input logic [31:0] old, input logic [31:0] ms,
                          input logic [31:0] epc, input logic [31:0] tvec);
        cyc_t c;
        int   nc;
        build_model(op, pc, a, rs1, rs1z, old, ms, epc, tvec);
        nc          = exp_q.size();
        csr_rdata   = old;
        mstatus_in  = ms;
        mepc_in     = epc;
        mtvec_in    = tvec;
        chk({tag, ".accept_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid    = 1'b1;
        in_op       = op;
        in_pc       = pc;
        in_csr_addr = a;
        in_rs1_data = rs1;
        in_rs1_zero = rs1z;
        @(negedge clk);
        for (int i = 0; i < nc; i++) begin
            c = exp_q[i];
            chk($sformatf("%s.c%0d.busy_rdy", tag, i + 1), {30'd0, busy, in_ready}, 32'd2);
            chk($sformatf("%s.c%0d.we", tag, i + 1), {31'd0, csr_we}, {31'd0, c.we});
            chk($sformatf("%s.c%0d.addr", tag, i + 1), {20'd0, csr_addr}, {20'd0, c.a});
            chk($sformatf("%s.c%0d.wdata", tag, i + 1), csr_wdata, c.wd);
            chk($sformatf("%s.c%0d.wb", tag, i + 1), {31'd0, wb_valid}, {31'd0, c.wb});
            chk($sformatf("%s.c%0d.wbd", tag, i + 1), wb_data, c.wbd);
            chk($sformatf("%s.c%0d.rv", tag, i + 1), {31'd0, redirect_valid}, {31'd0, c.rv});
            chk($sformatf("%s.c%0d.rpc", tag, i + 1), redirect_pc, c.rpc);
            // Inputs are latched, so scramble them while busy; drop valid before IDLE.
            in_valid    = (i == nc - 1) ? 1'b0 : 1'($urandom);
            in_op       = 3'($urandom);
            in_pc       = $urandom;
            in_csr_addr = 12'($urandom);
            in_rs1_data = $urandom;
            in_rs1_zero = 1'($urandom);
            if (i != nc - 1) @(negedge clk);
        end
        in_valid = 1'b0;
        if (nc != 0) @(negedge clk);
        chk_idle({tag, ".after"});
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_op       = '0;
        in_pc       = '0;
        in_csr_addr = '0;
        in_rs1_data = '0;
        in_rs1_zero = 1'b0;
        csr_rdata   = '0;
        mstatus_in  = '0;
        mepc_in     = '0;
        mtvec_in    = '0;
        #1;
        chk_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        run_op("csrrw", 3'd0, 32'h8000_0000, 12'h305, 32'h8000_0100, 1'b0,
               32'h0, 32'h0, 32'h0, 32'h0);
        run_op("csrrs_z", 3'd1, 32'h8000_0004, 12'h300, 32'h0, 1'b1,
               32'h1800, 32'h1800, 32'h0, 32'h0);
        run_op("csrrs", 3'd1, 32'h8000_0008, 12'h300, 32'h8, 1'b0,
               32'h1800, 32'h1800, 32'h0, 32'h0);
        run_op("csrrc", 3'd2, 32'h8000_000c, 12'h300, 32'h8, 1'b0,
               32'h1808, 32'h1808, 32'h0, 32'h0);
        run_op("ecall", 3'd3, 32'h8000_0044, 12'h000, 32'h0, 1'b0,
               32'h0, 32'h1808, 32'h0, 32'h8000_0201);
        run_op("mret", 3'd4, 32'h8000_0050, 12'h000, 32'h0, 1'b0,
               32'h0, 32'h1880, 32'h8000_0048, 32'h0);
        run_op("resv6", 3'd6, 32'h8000_0060, 12'h305, 32'hffff_ffff, 1'b0,
               32'h1234_5678, 32'h1888, 32'h0, 32'h0);

        // Reset landing in TRAP_CAUSE must clear outputs immediately and kill the redirect.
        mstatus_in  = 32'h1808;
        mtvec_in    = 32'h8000_0200;
        in_valid    = 1'b1;
        in_op       = 3'd3;
        in_pc       = 32'h8000_0070;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_trap.epc_addr", {20'd0, csr_addr}, 32'h341);
        @(negedge clk);
        chk("rst_trap.cause_addr", {20'd0, csr_addr}, 32'h342);
        #2 rst = 1'b1;
        #1;
        chk_idle("rst_trap.async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("rst_trap.no_redirect");
        run_op("ecall_after_rst", 3'd3, 32'h8000_0083, 12'h000, 32'h0, 1'b0,
               32'h0, 32'h0000_0008, 32'h0, 32'h8000_0303);

        for (int k = 0; k < 150; k++) begin
            logic [2:0] op;
            op = (k % 5 == 4) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            run_op($sformatf("rnd%0d", k), op, $urandom, 12'($urandom), $urandom,
                   1'($urandom), $urandom, $urandom, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Sequencer between decode/execute and the single-write-port machine-mode CSR register file.
- Executes Zicsr read-modify-write ops (CSRRW/CSRRS/CSRRC; the decoder supplies the immediate forms via rs1_data).
- Serialises the ECALL multi-register trap entry (mepc, mcause, mstatus) and MRET return into one CSR write per cycle.
- Issues the PC redirect to the fetch stage.

Parameters:
XLEN, 32, data/address width of pc and CSR values
ECALL_CAUSE, 32'd11, mcause value written on ECALL (environment call from M-mode)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  decoded CSR/trap instruction present
in_ready  out  1  block can accept; high only in IDLE
in_op  in  3  0=CSRRW 1=CSRRS 2=CSRRC 3=ECALL 4=MRET, 5-7 reserved
in_pc  in  XLEN  PC of the instruction
in_csr_addr  in  12  CSR address (CSR ops only)
in_rs1_data  in  XLEN  rs1 value or zero-extended uimm
in_rs1_zero  in  1  rs1 index / uimm is zero (suppresses write for CSRRS/CSRRC)
csr_we  out  1  CSR file write enable
csr_addr  out  12  CSR file address (read and write)
csr_wdata  out  XLEN  CSR file write data
csr_rdata  in  XLEN  combinational read data for csr_addr
mstatus_in  in  XLEN  current mstatus
mepc_in  in  XLEN  current mepc
mtvec_in  in  XLEN  current mtvec
wb_valid  out  1  one-cycle pulse: rd writeback of old CSR value
wb_data  out  XLEN  old CSR value
redirect_valid  out  1  one-cycle pulse: fetch must jump
redirect_pc  out  XLEN  redirect target
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any time): state=IDLE; all latched fields 0.
- Reset output values: csr_we, wb_valid, redirect_valid, busy = 0; csr_addr, csr_wdata, wb_data, redirect_pc = 0; in_ready = 1.
- A trap interrupted by reset is abandoned; partially written CSRs are restored by the CSR file's own reset.
- All outputs are driven from state plus latched fields. In IDLE every output except in_ready is 0.
- Accept: in_valid && in_ready at cycle 0 latches op, pc, csr_addr, rs1_data and rs1_zero. Next state by op:
  - CSR op -> CSR_EXEC
  - ECALL -> TRAP_EPC
  - MRET -> MRET_ST
  - reserved -> IDLE (silently dropped; no wb, no write)
- CSR_EXEC (1 cycle):
  - csr_addr = latched address; old = csr_rdata; wb_valid=1; wb_data=old.
  - CSRRW: we=1, wdata=rs1.
  - CSRRS: wdata = old | rs1; we = !rs1_zero.
  - CSRRC: wdata = old & ~rs1; we = !rs1_zero.
  - Next state IDLE.
  - Unimplemented addresses: csr_rdata returns 0 from the CSR file, and writes are ignored by that file. No special handling here.
- TRAP_EPC: we=1, addr=0x341, wdata = {pc[XLEN-1:2], 2'b00}. Next state TRAP_CAUSE.
- TRAP_CAUSE: we=1, addr=0x342, wdata=ECALL_CAUSE. Next state TRAP_ST.
- TRAP_ST:
  - we=1, addr=0x300.
  - wdata = mstatus_in with MPIE(7)=MIE(3), MIE(3)=0, MPP(12:11)=2'b11.
  - redirect_valid=1, redirect_pc = {mtvec_in[XLEN-1:2], 2'b00} (direct mode only).
  - Next state IDLE.
- MRET_ST:
  - we=1, addr=0x300.
  - wdata = mstatus_in with MIE(3)=MPIE(7), MPIE(7)=1, MPP=2'b11.
  - redirect_valid=1, redirect_pc = mepc_in.
  - Next state IDLE.
- Latency: CSR op = 1 cycle after accept; ECALL = 3; MRET = 1.
- in_ready returns high the cycle after the final state, so back-to-back ops cost op latency + 1 cycle.
- Only one CSR write per cycle. csr_we is never high in IDLE.
- in_valid held while busy is not consumed. Input fields may change freely while busy because they were latched at accept.

Test Plan:
- CSRRW addr 0x305, rs1=0x80000100, mtvec=0 -> cycle1: csr_we=1, addr=0x305, wdata=0x80000100, wb_valid=1, wb_data=0; in_ready high at cycle2.
- CSRRS addr 0x300, in_rs1_zero=1, mstatus=0x1800 -> wb_data=0x1800, csr_we=0. Repeat with rs1=0x8, rs1_zero=0 -> csr_we=1, wdata=0x1808.
- ECALL pc=0x80000044, mstatus=0x1808, mtvec=0x80000201:
  - cycle1: 0x341 <= 0x80000044.
  - cycle2: 0x342 <= 11.
  - cycle3: 0x300 <= 0x1880, redirect_valid=1, redirect_pc=0x80000200.
  - busy=1 for cycles 1-3.
- MRET mstatus=0x1880, mepc=0x80000048 -> cycle1: 0x300 <= 0x1888, redirect_pc=0x80000048; no wb_valid.
- Reserved op 6 with in_valid -> no csr_we, wb_valid or redirect; in_ready stays high.
- Assert rst during TRAP_CAUSE -> all outputs 0 immediately (async), in_ready=1, no redirect pulse; next ECALL runs the full 3-cycle sequence.
